// File: rtl/wb_register_file.sv
// Architectural register file terminating the writeback stage: one write port,
// two bypassed read ports for decode and one raw debug read port.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] DestRegReg,
    input  logic [DATA_W-1:0] Result,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);

    // Write interface: a write commits on the rising edge when RegWrite is high,
    // reset is low and DestRegReg is non-zero; there is no back-pressure.
    logic [DATA_W-1:0] storage_q [NREGS];
    logic [15:0]       write_count_q;
    logic [15:0]       write_count_d;
    logic              wr_en;

    // Reset is qualified here as well so a stray RegWrite during reset is inert.
    assign wr_en = RegWrite && !reset && (DestRegReg != '0);

    always_comb begin
        write_count_d = write_count_q;
        if (wr_en) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                storage_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            if (wr_en) begin
                storage_q[DestRegReg] <= Result;
            end
            write_count_q <= write_count_d;
        end
    end

    // $0 is never written, so its storage stays 0 and the bypass excludes it.
    always_comb begin
        ReadData1 = storage_q[ReadReg1];
        ReadData2 = storage_q[ReadReg2];
        if (wr_en && (DestRegReg == ReadReg1)) begin
            ReadData1 = Result;
        end
        if (wr_en && (DestRegReg == ReadReg2)) begin
            ReadData2 = Result;
        end
    end

    assign DbgData    = storage_q[DbgReg];
    assign WriteCount = write_count_q;

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Architectural register file (32 x 32-bit) that terminates the writeback interface.
- Accepts Result / DestRegReg / RegWrite from the writeback stage and serves two combinational read ports to the decode stage.
- Internal write-through bypass lets a same-cycle decode read see the value being written back. This removes the WB-to-ID hazard without an extra forwarding path.
- Register $0 is hardwired to zero. A third read port is provided for debug/bench visibility.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width
NREGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
RegWrite  input  1  write enable from writeback stage
DestRegReg  input  ADDR_W  write destination index from writeback stage
Result  input  DATA_W  write data from writeback stage
ReadReg1  input  ADDR_W  read port 1 index (rs)
ReadReg2  input  ADDR_W  read port 2 index (rt)
ReadData1  output  DATA_W  read port 1 data
ReadData2  output  DATA_W  read port 2 data
DbgReg  input  ADDR_W  debug read index
DbgData  output  DATA_W  debug read data (raw storage, no bypass)
WriteCount  output  16  number of committed non-$0 writes since reset, wraps at 16'hFFFF -> 0

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-high.
- Reset: while reset is high, all NREGS entries clear to 0 asynchronously and WriteCount clears to 0.
  - ReadData1, ReadData2 and DbgData therefore read 0 during reset and in the first cycle after reset.
- Write:
  - On the rising edge of clk with reset low, RegWrite=1 and DestRegReg!=0, storage[DestRegReg] <= Result and WriteCount increments by 1.
  - Write latency is 1 cycle: the value is visible in DbgData after that edge.
- Writes to $0:
  - A write with DestRegReg==0 is discarded; storage[0] stays 0.
  - WriteCount does not increment.
  - $0 always reads 0 on every port, bypass included.
- Reads: ReadData1 and ReadData2 are combinational on ReadReg1/ReadReg2, with zero-cycle latency.
- Bypass: if RegWrite=1, reset=0, DestRegReg!=0 and DestRegReg==ReadRegN, then ReadDataN = Result (the current input). Otherwise ReadDataN = storage[ReadRegN].
- Simultaneous reads: both ports may address the same register, including the bypassed one. Each port resolves independently.
- DbgData: always storage[DbgReg] with no bypass, so it shows only committed state.
- Reset during an operation: reset asserted in the same cycle as a write suppresses the write. Storage and WriteCount go to 0 regardless of RegWrite.
- Reset interaction with the writeback stage: the writeback stage already gates RegWrite with ~reset. This block still treats reset as dominant and never relies on that gating.
- WriteCount wrap: 16-bit unsigned counter, 0xFFFF + 1 -> 0x0000 with no saturation.
- X handling: none of the outputs go X when inputs are known. Out-of-range indices cannot occur when NREGS = 2**ADDR_W.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert reset mid-cycle (asynchronously) -> DbgData(r5)=0, ReadData1(ReadReg1=5)=0 and WriteCount=0 immediately, before any clk edge.
- Basic write/read: RegWrite=1, DestRegReg=8, Result=0x12345678, one edge.
  - Before the edge: DbgData(r8)=0 and ReadData1(ReadReg1=8)=0x12345678 via bypass.
  - After the edge with RegWrite=0: ReadData1=0x12345678 and WriteCount=1.
- $0 protection: RegWrite=1, DestRegReg=0, Result=0xFFFFFFFF with ReadReg1=ReadReg2=0 -> ReadData1=ReadData2=0 before and after the edge, DbgData(r0)=0, WriteCount unchanged.
- Dual-port bypass: r3=0x11111111 committed.
  - Then RegWrite=1, DestRegReg=3, Result=0x22222222, ReadReg1=3, ReadReg2=4 (r4=0x44444444) -> ReadData1=0x22222222, ReadData2=0x44444444, DbgData(r3)=0x11111111 until the edge.
- Reset beats write: reset=1 and RegWrite=1, DestRegReg=7, Result=0xA5A5A5A5 across a clk edge, then deassert reset -> DbgData(r7)=0, WriteCount=0.
- Counter wrap: issue 65536 writes to r1 with varying data -> WriteCount reads 0xFFFF after write 65535 and 0x0000 after write 65536; r1 holds the last written value.
